fc_flatten_buffer: RTL and testbench
====================================

// Module: fc_flatten_buffer
// PURPOSE
//  Flatten/collect stage directly upstream of the FC matrix-multiply (3-neuron FC layer).
//  Receives pooled feature-map pixels serially, IN_CH channels per beat, and packs
//  VEC elements into one wide vector. Emits that vector with a 1-cycle valid pulse,
//  which drives the FC i_in_valid / i_in_fmap directly.
//  Input and output are double-registered, so frame N+1 fills while frame N is presented.
// PARAMETERS
//  IN_CH   `CI        channels delivered per input beat (default 3)
//  VEC     `FC_IN_VEC elements per flattened vector (default 48); VEC % IN_CH == 0
//  BW      `OF_BW     bits per element (feature-map word width)
//  BEATS   VEC/IN_CH  localparam: beats per frame (16 at defaults)
// PORTS
//  clk            in   1          system clock, rising edge
//  reset_n        in   1          asynchronous active-low reset
//  i_frame_start  in   1          qualified by i_in_valid; marks beat 0 of a new frame
//  i_in_valid     in   1          input beat valid; no backpressure, always accepted
//  i_in_fmap      in   IN_CH*BW   channel c at bits [c*BW +: BW]
//  o_ot_valid     out  1          1-cycle pulse: o_ot_fmap holds a complete vector
//  o_ot_fmap      out  VEC*BW     element k at bits [k*BW +: BW]; held until next frame
//  o_busy         out  1          1 while a partial frame is in the pack register
//  o_err_partial  out  1          1-cycle pulse: partial frame discarded by i_frame_start
//  o_frame_cnt    out  8          completed frames since reset, wraps 255->0
// BEHAVIOUR
//  Reset: all outputs 0; beat counter 0; pack register 0; state EMPTY.
//  Element order: beat b, channel c -> element k = b*IN_CH + c. Each beat is written
//   verbatim into pack[k*BW +: BW]. No arithmetic, no sign change.
//  States:
//   EMPTY   cnt==0. On valid: write beat 0, cnt=1, go to FILL (BEATS==1: complete).
//           i_frame_start is ignored here (no error).
//   FILL    cnt in 1..BEATS-1. A valid beat without frame_start writes at cnt, cnt++.
//           A valid beat with frame_start: o_err_partial=1 on the next cycle; the
//           partial frame is dropped; the beat is written as beat 0; cnt=1; stay in FILL.
//           A valid beat at cnt==BEATS-1 completes the frame: cnt=0, go to EMPTY.
//  Completion: on the edge after the final beat is accepted, o_ot_fmap <= packed vector
//   (including the final beat's data), o_ot_valid=1 for exactly 1 cycle,
//   o_frame_cnt increments. Latency from final beat to valid is 1 clock.
//  Back-to-back: beat 0 of the next frame may arrive in the same cycle o_ot_valid is high.
//   o_ot_fmap is not disturbed until that next frame completes. Zero bubbles required.
//  Gaps: idle cycles (i_in_valid=0) between beats are allowed and change no state.
//  o_busy = (cnt != 0), registered; falls in the same cycle o_ot_valid rises.
//  Stale pack-register contents are never emitted; every element of a frame is rewritten.
//  reset_n low mid-frame: partial frame lost, outputs cleared asynchronously,
//   no o_ot_valid and no o_err_partial afterwards.
//  i_in_fmap is don't-care when i_in_valid=0; i_frame_start is ignored when i_in_valid=0.
// TESTING
//  T1 Single frame: 16 consecutive beats, beat b ch c = b*3+c+1
//     -> 1 cycle after beat 15: o_ot_valid=1 for 1 clk; element k = k+1; o_frame_cnt=1.
//  T2 Back-to-back: 3 frames, 48 contiguous beats, frame f data = 100*f+k
//     -> valid pulses at cycles 16/32/48 (relative to first beat); each vector is exact;
//        o_ot_fmap stable between pulses.
//  T3 Gapped: random 0-3 idle cycles between beats of one frame
//     -> single correct vector; o_busy high from first beat until the valid cycle.
//  T4 Abort: 5 beats, then frame_start with 16 fresh beats
//     -> o_err_partial pulses once; output holds only fresh data; o_frame_cnt +1 only.
//  T5 Reset mid-frame: 10 beats, reset_n low 2 clks, then 16 beats
//     -> all outputs 0 during reset; exactly 1 valid pulse after the 16 beats, correct data.
//  T6 Extremes and wrap: elements 0 and {BW{1'b1}} alternating, 256 frames
//     -> bit-exact output; o_frame_cnt wraps to 0 after frame 256.

Source files
------------

// File: rtl/fc_flatten_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : fc_flatten_buffer_if
// Brief    : Pixel-beat input and flattened-vector output bundle of the flatten buffer.
// Revision : 1.0
// ============================================================================
interface fc_flatten_buffer_if #(
    parameter int IN_CH = 3,
    parameter int VEC   = 48,
    parameter int BW    = 8
);
    logic                  i_frame_start;
    logic                  i_in_valid;
    logic [IN_CH*BW-1:0]   i_in_fmap;
    logic                  o_ot_valid;
    logic [VEC*BW-1:0]     o_ot_fmap;

    modport master (
        output i_frame_start, i_in_valid, i_in_fmap,
        input  o_ot_valid, o_ot_fmap
    );

    modport slave (
        input  i_frame_start, i_in_valid, i_in_fmap,
        output o_ot_valid, o_ot_fmap
    );
endinterface
`default_nettype wire

// File: rtl/fc_flatten_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fc_flatten_buffer
// Brief    : Packs IN_CH-wide pixel beats into a VEC-element vector for the FC layer.
// Revision : 1.0
// ============================================================================
module fc_flatten_buffer #(
    parameter int IN_CH = 3,
    parameter int VEC   = 48,
    parameter int BW    = 8
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    fc_flatten_buffer_if.slave      bus,
    output logic                    o_busy,
    output logic                    o_err_partial,
    output logic [7:0]              o_frame_cnt
);
    localparam int BEATS = VEC / IN_CH;
    localparam int SLICE = IN_CH * BW;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FILL  = 1'b1
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [VEC*BW-1:0] pack_q;
    logic [VEC*BW-1:0] pack_d;
    logic [VEC*BW-1:0] fmap_q;
    logic              valid_q;
    logic              busy_q;
    logic              err_q;
    logic [7:0]        frame_cnt_q;
    logic [CW-1:0]     idx_d;
    logic              last_d;

    // A frame_start beat mid-frame restarts at slot 0; in EMPTY the slot is 0 anyway.
    always_comb begin
        idx_d  = (state_q == ST_FILL && !bus.i_frame_start) ? cnt_q : '0;
        last_d = (idx_d == CW'(BEATS - 1));
        pack_d = pack_q;
        for (int b = 0; b < BEATS; b++) begin
            if (idx_d == CW'(b)) begin
                pack_d[b*SLICE +: SLICE] = bus.i_in_fmap;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            cnt_q       <= '0;
            pack_q      <= '0;
            fmap_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (bus.i_in_valid) begin
                pack_q <= pack_d;
                case (state_q)
                    ST_EMPTY: err_q <= 1'b0;
                    ST_FILL:  err_q <= bus.i_frame_start;
                    default:  err_q <= 1'b0;
                endcase
                if (last_d) begin
                    // Output captures the merged vector so the final beat is included.
                    fmap_q      <= pack_d;
                    valid_q     <= 1'b1;
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                    cnt_q       <= '0;
                    state_q     <= ST_EMPTY;
                    busy_q      <= 1'b0;
                end else begin
                    cnt_q   <= idx_d + 1'b1;
                    state_q <= ST_FILL;
                    busy_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.o_ot_valid = valid_q;
    assign bus.o_ot_fmap  = fmap_q;
    assign o_busy         = busy_q;
    assign o_err_partial  = err_q;
    assign o_frame_cnt    = frame_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_fc_flatten_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_flatten_buffer
// Brief    : Self-checking bench: hand-built vector table plus queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_fc_flatten_buffer;
    localparam int IN_CH = 3;
    localparam int VEC   = 48;
    localparam int BW    = 8;
    localparam int BEATS = VEC / IN_CH;
    localparam int W     = VEC * BW;
    localparam int IW    = IN_CH * BW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fc_flatten_buffer_if #(.IN_CH(IN_CH), .VEC(VEC), .BW(BW)) bus ();
    logic       o_busy;
    logic       o_err_partial;
    logic [7:0] o_frame_cnt;

    fc_flatten_buffer #(.IN_CH(IN_CH), .VEC(VEC), .BW(BW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .o_busy       (o_busy),
        .o_err_partial(o_err_partial),
        .o_frame_cnt  (o_frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: elements of the frame in progress, in arrival order.
    logic [BW-1:0] q[$];
    logic [W-1:0]  m_fmap;
    logic          m_valid;
    logic          m_err;
    logic [7:0]    m_cnt;

    typedef struct {
        bit            v;
        bit            fs;
        logic [IW-1:0] d;
        bit            e_valid;
        bit            e_err;
        bit            e_busy;
        logic [7:0]    e_cnt;
    } vec_t;
    vec_t tbl[23];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fmap  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 8'd0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, W'(bus.o_ot_valid), W'(m_valid));
        chk({tag, ".err"},   W'(o_err_partial),  W'(m_err));
        chk({tag, ".busy"},  W'(o_busy),         W'(q.size() != 0));
        chk({tag, ".cnt"},   W'(o_frame_cnt),    W'(m_cnt));
        chk({tag, ".fmap"},  bus.o_ot_fmap,      m_fmap);
    endtask

    function automatic logic [IW-1:0] beat(input int b, input int base);
        logic [IW-1:0] r;
        for (int c = 0; c < IN_CH; c++) r[c*BW +: BW] = BW'(base + b*IN_CH + c);
        return r;
    endfunction

    // One clock: drive, clock, advance the model, compare every output.
    task automatic cycle(input bit v, input bit fs, input logic [IW-1:0] d, input string tag);
        bus.i_in_valid    = v;
        bus.i_frame_start = fs;
        bus.i_in_fmap     = v ? d : IW'($urandom);
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (v) begin
            if (fs && q.size() != 0) begin
                m_err = 1'b1;
                q.delete();
            end
            for (int c = 0; c < IN_CH; c++) q.push_back(d[c*BW +: BW]);
            if (q.size() == VEC) begin
                for (int k = 0; k < VEC; k++) m_fmap[k*BW +: BW] = q[k];
                m_valid = 1'b1;
                m_cnt   = m_cnt + 8'd1;
                q.delete();
            end
        end
        check_all(tag);
    endtask

    task automatic send_frame(input int base, input int max_gap, input string tag);
        for (int b = 0; b < BEATS; b++) begin
            cycle(1'b1, b == 0, beat(b, base), tag);
            repeat ($urandom_range(0, max_gap)) cycle(1'b0, 1'b0, '0, tag);
        end
    endtask

    initial begin
        logic [W-1:0]  exp_vec;
        logic [IW-1:0] d;
        logic [7:0]    cnt_before;

        // Abort/restart sequence: 5 junk beats, an idle, then a fresh 16-beat frame.
        for (int i = 0; i < 23; i++) tbl[i] = '{1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 8'd0};
        for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, i == 0, {IW{1'b1}} ^ IW'(i), 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[5] = '{1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[6] = '{1'b1, 1'b1, beat(0, 1), 1'b0, 1'b1, 1'b1, 8'd0};
        for (int b = 1; b < BEATS; b++)
            tbl[6+b] = '{1'b1, 1'b0, beat(b, 1), b == BEATS-1, 1'b0, b != BEATS-1,
                         (b == BEATS-1) ? 8'd1 : 8'd0};
        tbl[22] = '{1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 8'd1};

        bus.i_in_valid    = 1'b0;
        bus.i_frame_start = 1'b0;
        bus.i_in_fmap     = '0;
        model_reset();
        #2;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            cycle(tbl[i].v, tbl[i].fs, tbl[i].d, "tbl_model");
            chk($sformatf("tbl[%0d].valid", i), W'(bus.o_ot_valid), W'(tbl[i].e_valid));
            chk($sformatf("tbl[%0d].err", i),   W'(o_err_partial),  W'(tbl[i].e_err));
            chk($sformatf("tbl[%0d].busy", i),  W'(o_busy),         W'(tbl[i].e_busy));
            chk($sformatf("tbl[%0d].cnt", i),   W'(o_frame_cnt),    W'(tbl[i].e_cnt));
        end
        for (int k = 0; k < VEC; k++) exp_vec[k*BW +: BW] = BW'(k + 1);
        chk("abort_fresh_vector", bus.o_ot_fmap, exp_vec);

        // Back-to-back frames, then a gapped frame.
        for (int f = 0; f < 3; f++) send_frame(100*f, 0, "b2b");
        for (int k = 0; k < VEC; k++) exp_vec[k*BW +: BW] = BW'(200 + k);
        chk("b2b_last_vector", bus.o_ot_fmap, exp_vec);
        cycle(1'b0, 1'b0, '0, "b2b_idle");
        send_frame(7, 3, "gapped");
        cycle(1'b0, 1'b0, '0, "gapped_idle");

        // Reset mid-frame.
        for (int b = 0; b < 10; b++) cycle(1'b1, b == 0, beat(b, 50), "pre_rst");
        bus.i_in_valid = 1'b0;
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all("in_rst");
        @(posedge clk); #1; check_all("in_rst");
        @(posedge clk); #1; check_all("in_rst");
        @(negedge clk);
        reset_n = 1'b1;
        send_frame(60, 0, "post_rst");
        for (int k = 0; k < VEC; k++) exp_vec[k*BW +: BW] = BW'(60 + k);
        chk("post_rst_vector", bus.o_ot_fmap, exp_vec);
        chk("post_rst_cnt", W'(o_frame_cnt), W'(8'd1));

        // Extremes and counter wrap.
        cnt_before = m_cnt;
        for (int f = 0; f < 256; f++) begin
            for (int b = 0; b < BEATS; b++) begin
                for (int c = 0; c < IN_CH; c++)
                    d[c*BW +: BW] = (((b*IN_CH + c + f) % 2) == 1) ? {BW{1'b1}} : {BW{1'b0}};
                cycle(1'b1, b == 0, d, "extreme");
            end
        end
        chk("wrap_cnt", W'(o_frame_cnt), W'(cnt_before));

        // Random traffic: random data, gaps and occasional mid-frame restarts.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) cycle(1'b0, $urandom_range(0, 1) == 1, '0, "rand");
            else cycle(1'b1, $urandom_range(0, 9) == 0, IW'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
